// File: rtl/fm_voice_scheduler_if.sv
// ---------------------------------------------------------------------------
// fm_voice_scheduler_if
//   Operator request/accept bus between the voice scheduler and the shared
//   FM operator/sine datapath.
//   master (scheduler): IO_op_req, IO_op_voice, IO_op_sel, IO_op_mod_in out;
//                       IO_op_ack, IO_op_result in
//   slave  (datapath) : mirror image of master
//   A transfer happens on every cycle with IO_op_req && IO_op_ack;
//   IO_op_result is valid in that same cycle.
// ---------------------------------------------------------------------------
interface fm_voice_scheduler_if #(
  parameter int VOICES   = 8,
  parameter int SAMPLE_W = 12
);
  localparam int VI_W = $clog2(VOICES);

  logic                       IO_op_req;
  logic [VI_W-1:0]            IO_op_voice;
  logic                       IO_op_sel;
  logic signed [SAMPLE_W-1:0] IO_op_mod_in;
  logic                       IO_op_ack;
  logic signed [SAMPLE_W-1:0] IO_op_result;

  modport master (
    output IO_op_req, IO_op_voice, IO_op_sel, IO_op_mod_in,
    input  IO_op_ack, IO_op_result
  );

  modport slave (
    input  IO_op_req, IO_op_voice, IO_op_sel, IO_op_mod_in,
    output IO_op_ack, IO_op_result
  );
endinterface

// File: rtl/fm_voice_scheduler.sv
// ---------------------------------------------------------------------------
// fm_voice_scheduler
//   Once per audio strobe, walks voices 0..VOICES-1; for each enabled voice it
//   issues a modulator request then a carrier request (carrier phase-modulated
//   by the modulator result), sums the carrier outputs and publishes one
//   mixed sample.
//
//   Optional build macro: SCHED_MOD_FEEDBACK_EN
//     defined   : per-voice modulator self-feedback (last result >>> 1) is
//                 applied as the modulator's mod_in and persists across frames.
//     undefined : modulator mod_in is 0, no feedback storage.
//
// Ports
//   IO_main_clk     in  system clock
//   IO_rst_n        in  asynchronous active-low reset
//   IO_audio_clk    in  1-cycle sample strobe (IO_main_clk domain)
//   IO_voice_en     in  per-voice enable, sampled as the scan reaches a voice
//   op              operator bus (master side), see fm_voice_scheduler_if
//   IO_sample       out signed mixed sample, held between frames
//   IO_sample_valid out 1-cycle pulse while IO_sample holds a new frame
//   IO_busy         out frame in progress
//   IO_overrun      out sticky: strobe seen while busy
//   IO_overrun_clr  in  clears IO_overrun (a concurrent set wins)
// ---------------------------------------------------------------------------
module fm_voice_scheduler #(
  parameter  int VOICES   = 8,
  parameter  int SAMPLE_W = 12,
  localparam int VI_W     = $clog2(VOICES),
  localparam int ACC_W    = SAMPLE_W + VI_W
) (
  input  logic                    IO_main_clk,
  input  logic                    IO_rst_n,
  input  logic                    IO_audio_clk,
  input  logic [VOICES-1:0]       IO_voice_en,
  fm_voice_scheduler_if.master    op,
  output logic signed [ACC_W-1:0] IO_sample,
  output logic                    IO_sample_valid,
  output logic                    IO_busy,
  output logic                    IO_overrun,
  input  logic                    IO_overrun_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_MOD,
    S_CAR,
    S_PUBLISH
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [VI_W-1:0]            r_voice;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    r_sample;
  logic signed [SAMPLE_W-1:0] r_mod;
  logic                       r_overrun;

  logic                       w_ack;
  logic                       w_last;
  logic signed [SAMPLE_W-1:0] w_result;
  logic signed [ACC_W-1:0]    w_res_ext;
  logic signed [ACC_W-1:0]    w_acc_add;
  logic signed [SAMPLE_W-1:0] w_mod_fb;

  assign w_ack     = op.IO_op_ack;
  assign w_result  = op.IO_op_result;
  assign w_last    = (r_voice == VI_W'(VOICES - 1));
  assign w_res_ext = {{VI_W{w_result[SAMPLE_W-1]}}, w_result};
  assign w_acc_add = r_acc + w_res_ext;

`ifdef SCHED_MOD_FEEDBACK_EN
  logic signed [SAMPLE_W-1:0] r_fb [VOICES];

  always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
    if (!IO_rst_n) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        r_fb[i] <= '0;
      end
    end else if (r_state == S_MOD && w_ack) begin
      r_fb[r_voice] <= w_result >>> 1;
    end
  end

  assign w_mod_fb = r_fb[r_voice];
`else
  assign w_mod_fb = '0;
`endif

  // State register
  always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
    if (!IO_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (IO_audio_clk) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (IO_voice_en[r_voice]) w_state_next = S_MOD;
        else if (w_last)          w_state_next = S_PUBLISH;
      end
      S_MOD: begin
        if (w_ack) w_state_next = S_CAR;
      end
      S_CAR: begin
        if (w_ack) w_state_next = w_last ? S_PUBLISH : S_SCAN;
      end
      S_PUBLISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and registered data only
  always_comb begin
    op.IO_op_req    = 1'b0;
    op.IO_op_sel    = 1'b0;
    op.IO_op_mod_in = '0;
    op.IO_op_voice  = r_voice;
    case (r_state)
      S_MOD: begin
        op.IO_op_req    = 1'b1;
        op.IO_op_mod_in = w_mod_fb;
      end
      S_CAR: begin
        op.IO_op_req    = 1'b1;
        op.IO_op_sel    = 1'b1;
        op.IO_op_mod_in = r_mod;
      end
      default: ;
    endcase
  end

  assign IO_busy         = (r_state != S_IDLE);
  assign IO_sample_valid = (r_state == S_PUBLISH);
  assign IO_sample       = r_sample;
  assign IO_overrun      = r_overrun;

  // Frame datapath: voice index, modulator latch, accumulator, published sample
  always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
    if (!IO_rst_n) begin
      r_voice  <= '0;
      r_acc    <= '0;
      r_mod    <= '0;
      r_sample <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IO_audio_clk) begin
            r_voice <= '0;
            r_acc   <= '0;
          end
        end
        S_SCAN: begin
          if (!IO_voice_en[r_voice] && !w_last) r_voice <= r_voice + 1'b1;
        end
        S_MOD: begin
          if (w_ack) r_mod <= w_result;
        end
        S_CAR: begin
          if (w_ack) begin
            r_acc <= w_acc_add;
            if (!w_last) r_voice <= r_voice + 1'b1;
          end
        end
        default: ;
      endcase

      // The sample register is loaded on entry to PUBLISH so that the new
      // value and the valid pulse appear together; a final carrier ack folds
      // its result in on the same edge.
      if (w_state_next == S_PUBLISH && r_state != S_PUBLISH) begin
        r_sample <= (r_state == S_CAR) ? w_acc_add : r_acc;
      end
    end
  end

  // Sticky overrun: set has priority over clear
  always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
    if (!IO_rst_n) begin
      r_overrun <= 1'b0;
    end else if (IO_audio_clk && r_state != S_IDLE) begin
      r_overrun <= 1'b1;
    end else if (IO_overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fm_voice_scheduler
//   Directed bench for fm_voice_scheduler (VOICES=8, SAMPLE_W=12). A
//   datapath responder answers requests from per-voice result tables with a
//   programmable ack delay and logs every transfer.
// ---------------------------------------------------------------------------
module tb_fm_voice_scheduler;

  localparam int VOICES   = 8;
  localparam int SAMPLE_W = 12;
  localparam int VI_W     = 3;
  localparam int ACC_W    = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              strobe = 1'b0;
  logic [VOICES-1:0] en = '0;
  logic              clr = 1'b0;
  logic signed [ACC_W-1:0] sample;
  logic              valid;
  logic              busy;
  logic              overrun;

  fm_voice_scheduler_if #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W)) bus ();

  fm_voice_scheduler #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W)) dut (
    .IO_main_clk     (clk),
    .IO_rst_n        (rst_n),
    .IO_audio_clk    (strobe),
    .IO_voice_en     (en),
    .op              (bus),
    .IO_sample       (sample),
    .IO_sample_valid (valid),
    .IO_busy         (busy),
    .IO_overrun      (overrun),
    .IO_overrun_clr  (clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath model
  int mod_val [VOICES];
  int car_val [VOICES];
  int delay = 0;
  int wcnt  = 0;
  logic [VI_W-1:0]            hv;
  logic                       hs;
  logic signed [SAMPLE_W-1:0] hm;
  logic                       hstable;
  int q_v[$], q_s[$], q_m[$], q_h[$], q_st[$];

  initial begin
    bus.IO_op_ack    = 1'b0;
    bus.IO_op_result = '0;
  end

  // Decisions are taken at the falling edge so ack is settled well before
  // the rising edge that completes the transfer.
  always @(negedge clk) begin
    bus.IO_op_ack = 1'b0;
    if (bus.IO_op_req === 1'b1) begin
      if (wcnt == 0) begin
        hv = bus.IO_op_voice;
        hs = bus.IO_op_sel;
        hm = bus.IO_op_mod_in;
        hstable = 1'b1;
      end else if (bus.IO_op_voice !== hv || bus.IO_op_sel !== hs || bus.IO_op_mod_in !== hm) begin
        hstable = 1'b0;
      end
      if (wcnt >= delay) begin
        bus.IO_op_ack    = 1'b1;
        bus.IO_op_result = bus.IO_op_sel ? SAMPLE_W'(car_val[bus.IO_op_voice])
                                         : SAMPLE_W'(mod_val[bus.IO_op_voice]);
        q_v.push_back(int'(bus.IO_op_voice));
        q_s.push_back(int'(bus.IO_op_sel));
        q_m.push_back(int'(bus.IO_op_mod_in));
        q_h.push_back(wcnt + 1);
        q_st.push_back(int'(hstable));
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_v.delete(); q_s.delete(); q_m.delete(); q_h.delete(); q_st.delete();
  endtask

  task automatic pulse_strobe();
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
  endtask

  // Cycles counted from the edge that samples the strobe
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 300) chk("frame_timeout", valid, 1);
  endtask

  task automatic run_frame(output int cyc);
    pulse_strobe();
    wait_valid(cyc);
  endtask

  int cyc;
  int nvalid;
  int nfound;

  initial begin
    for (int v = 0; v < VOICES; v++) begin
      mod_val[v] = 0;
      car_val[v] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",     bus.IO_op_req, 0);
    chk("rst_voice",   bus.IO_op_voice, 0);
    chk("rst_sel",     bus.IO_op_sel, 0);
    chk("rst_mod_in",  bus.IO_op_mod_in, 0);
    chk("rst_sample",  sample, 0);
    chk("rst_valid",   valid, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: nothing enabled -> 8 scans then publish
    en = 8'h00;
    clear_log();
    pulse_strobe();
    chk("t1_busy_after_strobe", busy, 1);
    wait_valid(cyc);
    chk("t1_cycles", cyc, 8);
    chk("t1_sample", sample, 0);
    chk("t1_no_transfers", q_v.size(), 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", valid, 0);
    chk("t1_idle", busy, 0);

    // 2: only voice 3
    en = 8'h08;
    mod_val[3] = 100;
    car_val[3] = -200;
    clear_log();
    run_frame(cyc);
    chk("t2_cycles", cyc, 10);
    chk("t2_sample", sample, -200);
    chk("t2_count", q_v.size(), 2);
    if (q_v.size() == 2) begin
      chk("t2_x0_voice", q_v[0], 3);
      chk("t2_x0_sel",   q_s[0], 0);
      chk("t2_x0_mod",   q_m[0], 0);
      chk("t2_x1_voice", q_v[1], 3);
      chk("t2_x1_sel",   q_s[1], 1);
      chk("t2_x1_mod",   q_m[1], 100);
    end

    // 3: all voices, positive and negative full scale
    en = 8'hFF;
    for (int v = 0; v < VOICES; v++) begin
      mod_val[v] = v * 10 - 30;
      car_val[v] = 2047;
    end
    clear_log();
    run_frame(cyc);
    chk("t3_cycles", cyc, 24);
    chk("t3_sample_max", sample, 16376);
    chk("t3_count", q_v.size(), 16);
    if (q_v.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk("t3_order_voice", q_v[k], k / 2);
        chk("t3_order_sel",   q_s[k], k % 2);
        if (k % 2 == 1) chk("t3_car_mod_in", q_m[k], (k / 2) * 10 - 30);
      end
    end
    for (int v = 0; v < VOICES; v++) car_val[v] = -2048;
    run_frame(cyc);
    chk("t3_sample_min", sample, -16384);

    // 4: five-cycle ack delay on every transfer
    en = 8'h05;
    car_val[0] = 300;
    car_val[2] = -50;
    delay = 5;
    clear_log();
    run_frame(cyc);
    chk("t4_sample", sample, 250);
    chk("t4_count", q_v.size(), 4);
    for (int k = 0; k < q_h.size(); k++) begin
      chk("t4_hold_cycles", q_h[k], 6);
      chk("t4_hold_stable", q_st[k], 1);
    end
    if (q_v.size() == 4) chk("t4_car_mod_in", q_m[3], mod_val[2]);
    delay = 0;

    // 5: overrun
    en = 8'hFF;
    for (int v = 0; v < VOICES; v++) car_val[v] = 1;
    pulse_strobe();
    repeat (3) @(posedge clk);
    pulse_strobe();
    chk("t5_overrun_set", overrun, 1);
    chk("t5_still_busy", busy, 1);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nvalid++;
    end
    chk("t5_single_valid", nvalid, 1);
    chk("t5_sample", sample, 8);
    chk("t5_overrun_sticky", overrun, 1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("t5_overrun_clr", overrun, 0);
    pulse_strobe();
    repeat (2) @(posedge clk);
    #1 clr = 1'b1; strobe = 1'b1;
    @(posedge clk); #1 clr = 1'b0; strobe = 1'b0;
    chk("t5_set_beats_clr", overrun, 1);
    wait_valid(cyc);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;

    // 6: reset during the carrier request of voice 4
    en = 8'h10;
    mod_val[4] = 100;
    car_val[4] = 77;
    delay = 3;
    pulse_strobe();
    nfound = 0;
    while (!(bus.IO_op_req === 1'b1 && bus.IO_op_sel === 1'b1 && bus.IO_op_voice === 3'd4) && nfound < 100) begin
      @(posedge clk); #1;
      nfound++;
    end
    chk("t6_reached_car4", bus.IO_op_req & bus.IO_op_sel, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_cleared",    bus.IO_op_req, 0);
    chk("t6_busy_cleared",   busy, 0);
    chk("t6_sample_cleared", sample, 0);
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nvalid++;
    end
    chk("t6_no_valid", nvalid, 0);
    @(negedge clk) rst_n = 1'b1;
    delay = 0;
    clear_log();
    run_frame(cyc);
    chk("t6_cycles", cyc, 10);
    chk("t6_sample", sample, 77);
    chk("t6_count", q_v.size(), 2);
    if (q_v.size() == 2) chk("t6_mod_in_after_rst", q_m[0], 0);
    clear_log();
    run_frame(cyc);
    if (q_v.size() == 2) begin
`ifdef SCHED_MOD_FEEDBACK_EN
      chk("t6_fb_mod_in", q_m[0], 50);
`else
      chk("t6_mod_in_zero", q_m[0], 0);
`endif
      chk("t6_car_mod_in", q_m[1], 100);
    end else begin
      chk("t6_frame2_count", q_v.size(), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
